// File: rtl/arm_mem_pkg.sv
// Shared types and helpers for the MEM-stage memory controller:
// FSM state encoding, default address map and byte-to-word translation.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } mem_state_t;

    localparam int DEFAULT_BASE_ADDR  = 1024;
    localparam int DEFAULT_BYTE_SHIFT = 2;

    typedef struct packed {
        logic        in_range;
        logic [63:0] word_idx;
    } addr_map_t;

    // Word index relative to the base, plus whether it lands inside a 2**aw-word SRAM.
    function automatic addr_map_t map_addr(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int          shift,
        input int          aw
    );
        addr_map_t   m;
        logic [63:0] off;
        off        = addr - base;
        m.word_idx = off >> shift;
        m.in_range = (addr >= base) && (m.word_idx < (64'd1 << aw));
        return m;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that stops at zero; times the SRAM wait states.
module mem_wait_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_wait_ctrl.sv
// MEM-stage controller: drives a word-addressed SRAM with fixed wait states and
// holds o_ready low while an access is in flight so the pipeline freezes.
module mem_wait_ctrl
    import arm_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 5,
    parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int BYTE_SHIFT  = DEFAULT_BYTE_SHIFT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_mem_r_en,
    input  logic               i_mem_w_en,
    input  logic [ADDR_W-1:0]  i_address,
    input  logic [DATA_W-1:0]  i_wr_data,
    output logic [DATA_W-1:0]  o_rd_data,
    output logic               o_ready,
    output logic               o_addr_err,
    output logic [SRAM_AW-1:0] o_sram_addr,
    output logic [DATA_W-1:0]  o_sram_wdata,
    input  logic [DATA_W-1:0]  i_sram_rdata,
    output logic               o_sram_we_n,
    output logic               o_sram_oe_n
);

    localparam int             CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    mem_state_t         r_state;
    mem_state_t         w_next_state;
    logic               w_req;
    logic               w_store;
    logic               w_start;
    logic               w_finish;
    logic               w_cnt_zero;
    logic               w_ready;
    addr_map_t          w_map;
    logic               w_unused_map_bits;

    logic               r_is_store;
    logic               r_in_range;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic [DATA_W-1:0]  r_sram_wdata;
    logic               r_we_n;
    logic               r_oe_n;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_addr_err;

    // A simultaneous load and store is treated as a store.
    assign w_req    = i_mem_r_en | i_mem_w_en;
    assign w_store  = i_mem_w_en;
    assign w_map    = map_addr(64'(i_address), 64'(BASE_ADDR), BYTE_SHIFT, SRAM_AW);
    assign w_unused_map_bits = ^w_map.word_idx[63:SRAM_AW];
    assign w_start  = (r_state == IDLE) && w_req;
    assign w_finish = (r_state == ACCESS) && w_cnt_zero;

    mem_wait_counter #(
        .WIDTH(CNT_W)
    ) u_wait_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_start),
        .i_load_val(LOAD_VAL),
        .i_dec     (r_state == ACCESS),
        .o_zero    (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // o_ready is combinational in IDLE so the freeze asserts in the request cycle.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b1;
        case (r_state)
            IDLE: begin
                w_ready = ~w_req;
                if (w_req) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                w_ready = 1'b0;
                if (w_cnt_zero) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_ready      = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operands are latched once per access; out-of-range accesses keep both strobes high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store   <= 1'b0;
            r_in_range   <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_we_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_rd_data    <= '0;
            r_addr_err   <= 1'b0;
        end else if (w_start) begin
            r_is_store   <= w_store;
            r_in_range   <= w_map.in_range;
            r_sram_addr  <= w_map.word_idx[SRAM_AW-1:0];
            r_sram_wdata <= i_wr_data;
            r_we_n       <= ~(w_store & w_map.in_range);
            r_oe_n       <= ~(~w_store & w_map.in_range);
            if (!w_map.in_range) begin
                r_addr_err <= 1'b1;
            end
        end else if (w_finish) begin
            r_we_n <= 1'b1;
            r_oe_n <= 1'b1;
            if (!r_is_store) begin
                r_rd_data <= r_in_range ? i_sram_rdata : '0;
            end
        end
    end

    assign o_ready      = w_ready;
    assign o_rd_data    = r_rd_data;
    assign o_addr_err   = r_addr_err;
    assign o_sram_addr  = r_sram_addr;
    assign o_sram_wdata = r_sram_wdata;
    assign o_sram_we_n  = r_we_n;
    assign o_sram_oe_n  = r_oe_n;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Directed bench for mem_wait_ctrl: one instance with 5 wait states, one with 1,
// each attached to a small SRAM model that commits a write only after a full strobe.
module tb_mem_wait_ctrl;

    logic        clk;
    logic        rstN;
    logic        clearMem;

    logic        rEn5, wEn5;
    logic [31:0] addr5, wdata5, rdData5, sramWdata5, sramRdata5;
    logic        ready5, addrErr5, weN5, oeN5;
    logic [17:0] sramAddr5;

    logic        rEn1, wEn1;
    logic [31:0] addr1, wdata1, rdData1, sramWdata1, sramRdata1;
    logic        ready1, addrErr1, weN1, oeN1;
    logic [17:0] sramAddr1;

    logic [31:0] mem5 [0:255];
    logic [31:0] mem1 [0:255];
    int          wrCnt5;
    int          wrCnt1;

    int          checks;
    int          errors;

    logic [6:0]  readyObs, weObs, oeObs;
    logic [17:0] addrObs [0:6];
    logic [31:0] rdObs   [0:6];
    logic [2:0]  readyObs1, oeObs1;
    logic [31:0] rdObs1  [0:2];

    mem_wait_ctrl #(.WAIT_CYCLES(5)) dut5 (
        .clk         (clk),
        .rst_n       (rstN),
        .i_mem_r_en  (rEn5),
        .i_mem_w_en  (wEn5),
        .i_address   (addr5),
        .i_wr_data   (wdata5),
        .o_rd_data   (rdData5),
        .o_ready     (ready5),
        .o_addr_err  (addrErr5),
        .o_sram_addr (sramAddr5),
        .o_sram_wdata(sramWdata5),
        .i_sram_rdata(sramRdata5),
        .o_sram_we_n (weN5),
        .o_sram_oe_n (oeN5)
    );

    mem_wait_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .clk         (clk),
        .rst_n       (rstN),
        .i_mem_r_en  (rEn1),
        .i_mem_w_en  (wEn1),
        .i_address   (addr1),
        .i_wr_data   (wdata1),
        .o_rd_data   (rdData1),
        .o_ready     (ready1),
        .o_addr_err  (addrErr1),
        .o_sram_addr (sramAddr1),
        .o_sram_wdata(sramWdata1),
        .i_sram_rdata(sramRdata1),
        .o_sram_we_n (weN1),
        .o_sram_oe_n (oeN1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sramRdata5 = oeN5 ? 32'h0 : mem5[sramAddr5[7:0]];
    assign sramRdata1 = oeN1 ? 32'h0 : mem1[sramAddr1[7:0]];

    // A write lands only once the strobe has been held for the full access length.
    always @(posedge clk) begin
        if (clearMem) begin
            for (int i = 0; i < 256; i++) mem5[i] <= 32'h0;
            wrCnt5 <= 0;
        end else if (weN5) begin
            wrCnt5 <= 0;
        end else begin
            if (wrCnt5 == 4) mem5[sramAddr5[7:0]] <= sramWdata5;
            wrCnt5 <= wrCnt5 + 1;
        end
    end

    always @(posedge clk) begin
        if (clearMem) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 32'h0;
            wrCnt1 <= 0;
        end else if (weN1) begin
            wrCnt1 <= 0;
        end else begin
            if (wrCnt1 == 0) mem1[sramAddr1[7:0]] <= sramWdata1;
            wrCnt1 <= wrCnt1 + 1;
        end
    end

    // Holds the request for the whole stall (cycles 0..6) like a frozen pipeline would.
    task automatic runAccess5(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        rEn5 = rd; wEn5 = wr; addr5 = addr; wdata5 = wdata;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            readyObs[c] = ready5;
            weObs[c]    = ~weN5;
            oeObs[c]    = ~oeN5;
            addrObs[c]  = sramAddr5;
            rdObs[c]    = rdData5;
            @(posedge clk); #1;
        end
        rEn5 = 1'b0; wEn5 = 1'b0;
    endtask

    task automatic runAccess1(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        rEn1 = rd; wEn1 = wr; addr1 = addr; wdata1 = wdata;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            readyObs1[c] = ready1;
            oeObs1[c]    = ~oeN1;
            rdObs1[c]    = rdData1;
            @(posedge clk); #1;
        end
        rEn1 = 1'b0; wEn1 = 1'b0;
    endtask

    task automatic test_reset;
        rstN = 1'b0; clearMem = 1'b1;
        rEn5 = 0; wEn5 = 0; addr5 = 0; wdata5 = 0;
        rEn1 = 0; wEn1 = 0; addr1 = 0; wdata1 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ready5 !== 1'b1)     begin errors++; $display("FAIL reset_ready got %b want 1", ready5); end
        checks++; if (rdData5 !== 32'h0)   begin errors++; $display("FAIL reset_rd_data got %h want 0", rdData5); end
        checks++; if (addrErr5 !== 1'b0)   begin errors++; $display("FAIL reset_addr_err got %b want 0", addrErr5); end
        checks++; if ({weN5, oeN5} !== 2'b11) begin errors++; $display("FAIL reset_strobes got %b want 11", {weN5, oeN5}); end
        checks++; if (sramAddr5 !== 18'h0) begin errors++; $display("FAIL reset_sram_addr got %h want 0", sramAddr5); end
        checks++; if (sramWdata5 !== 32'h0) begin errors++; $display("FAIL reset_sram_wdata got %h want 0", sramWdata5); end
        @(posedge clk); #1;
        rstN = 1'b1; clearMem = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_access;
        logic sawStrobe;
        rEn5 = 0; wEn5 = 1; addr5 = 32'd1040; wdata5 = 32'h12345678;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (weN5 !== 1'b0) begin errors++; $display("FAIL mid_we_active got %b want 0", weN5); end
        wEn5 = 0;
        rstN = 1'b0;
        #1;
        checks++; if (weN5 !== 1'b1) begin errors++; $display("FAIL mid_we_async_release got %b want 1", weN5); end
        checks++; if (sramAddr5 !== 18'h0) begin errors++; $display("FAIL mid_sram_addr got %h want 0", sramAddr5); end
        @(posedge clk); #1;
        rstN = 1'b1;
        sawStrobe = 1'b0;
        @(negedge clk);
        checks++; if (ready5 !== 1'b1) begin errors++; $display("FAIL mid_ready_after got %b want 1", ready5); end
        repeat (7) begin
            @(negedge clk);
            if (weN5 !== 1'b1) sawStrobe = 1'b1;
        end
        checks++; if (sawStrobe !== 1'b0) begin errors++; $display("FAIL mid_no_strobe_after got %b want 0", sawStrobe); end
        checks++; if (mem5[4] !== 32'h0) begin errors++; $display("FAIL mid_no_partial_write got %h want 0", mem5[4]); end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load;
        runAccess5(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        checks++; if (readyObs !== 7'b1000000) begin errors++; $display("FAIL store_ready got %b want 1000000", readyObs); end
        checks++; if (weObs !== 7'b0111110) begin errors++; $display("FAIL store_we got %b want 0111110", weObs); end
        checks++; if (oeObs !== 7'b0000000) begin errors++; $display("FAIL store_oe got %b want 0000000", oeObs); end
        checks++; if (addrObs[1] !== 18'h0 || addrObs[5] !== 18'h0) begin errors++; $display("FAIL store_addr got %h/%h want 0", addrObs[1], addrObs[5]); end
        checks++; if (mem5[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL store_mem got %h want deadbeef", mem5[0]); end
        runAccess5(1'b1, 1'b0, 32'd1024, 32'h0);
        checks++; if (readyObs !== 7'b1000000) begin errors++; $display("FAIL load_ready got %b want 1000000", readyObs); end
        checks++; if (oeObs !== 7'b0111110) begin errors++; $display("FAIL load_oe got %b want 0111110", oeObs); end
        checks++; if (rdObs[5] !== 32'h0 || rdObs[6] !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got %h/%h want 0/deadbeef", rdObs[5], rdObs[6]); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (rdData5 !== 32'hDEADBEEF || ready5 !== 1'b1) begin errors++; $display("FAIL idle_hold got %h/%b want deadbeef/1", rdData5, ready5); end
        @(posedge clk); #1;
    endtask

    task automatic test_address_map;
        runAccess5(1'b0, 1'b1, 32'd1028, 32'h11112222);
        checks++; if (addrObs[3] !== 18'h1) begin errors++; $display("FAIL map_store_1028 got %h want 1", addrObs[3]); end
        runAccess5(1'b1, 1'b0, 32'd1028, 32'h0);
        checks++; if (addrObs[3] !== 18'h1 || rdObs[6] !== 32'h11112222) begin errors++; $display("FAIL map_load_1028 got %h/%h want 1/11112222", addrObs[3], rdObs[6]); end
        runAccess5(1'b1, 1'b0, 32'd1031, 32'h0);
        checks++; if (addrObs[3] !== 18'h1 || rdObs[6] !== 32'h11112222) begin errors++; $display("FAIL map_load_1031 got %h/%h want 1/11112222", addrObs[3], rdObs[6]); end
        checks++; if (addrErr5 !== 1'b0) begin errors++; $display("FAIL map_no_err got %b want 0", addrErr5); end
    endtask

    task automatic test_out_of_range;
        runAccess5(1'b1, 1'b0, 32'd1020, 32'h0);
        checks++; if (readyObs !== 7'b1000000) begin errors++; $display("FAIL oor_ready got %b want 1000000", readyObs); end
        checks++; if (weObs !== 7'b0 || oeObs !== 7'b0) begin errors++; $display("FAIL oor_strobes got %b/%b want 0/0", weObs, oeObs); end
        checks++; if (rdObs[6] !== 32'h0) begin errors++; $display("FAIL oor_rd_data got %h want 0", rdObs[6]); end
        checks++; if (addrErr5 !== 1'b1) begin errors++; $display("FAIL oor_addr_err got %b want 1", addrErr5); end
        runAccess5(1'b1, 1'b0, 32'd1049596, 32'h0);
        checks++; if (addrObs[3] !== 18'h3FFFF || oeObs !== 7'b0111110) begin errors++; $display("FAIL top_word got %h/%b want 3ffff/0111110", addrObs[3], oeObs); end
        runAccess5(1'b0, 1'b1, 32'd1049600, 32'h77);
        checks++; if (weObs !== 7'b0 || readyObs !== 7'b1000000) begin errors++; $display("FAIL past_top got %b/%b want 0/1000000", weObs, readyObs); end
        runAccess5(1'b1, 1'b0, 32'd1024, 32'h0);
        checks++; if (rdObs[6] !== 32'hDEADBEEF || addrErr5 !== 1'b1) begin errors++; $display("FAIL oor_sticky got %h/%b want deadbeef/1", rdObs[6], addrErr5); end
    endtask

    task automatic test_simultaneous;
        runAccess5(1'b1, 1'b1, 32'd1032, 32'h5);
        checks++; if (weObs !== 7'b0111110 || oeObs !== 7'b0) begin errors++; $display("FAIL both_strobes got %b/%b want 0111110/0", weObs, oeObs); end
        checks++; if (rdObs[6] !== 32'hDEADBEEF) begin errors++; $display("FAIL both_rd_unchanged got %h want deadbeef", rdObs[6]); end
        runAccess5(1'b1, 1'b0, 32'd1032, 32'h0);
        checks++; if (rdObs[6] !== 32'h5) begin errors++; $display("FAIL both_readback got %h want 5", rdObs[6]); end
    endtask

    task automatic test_back_to_back;
        runAccess1(1'b0, 1'b1, 32'd1032, 32'hCAFE0001);
        runAccess1(1'b0, 1'b1, 32'd1036, 32'hCAFE0002);
        checks++; if (mem1[2] !== 32'hCAFE0001 || mem1[3] !== 32'hCAFE0002) begin errors++; $display("FAIL b2b_stores got %h/%h want cafe0001/cafe0002", mem1[2], mem1[3]); end
        runAccess1(1'b1, 1'b0, 32'd1032, 32'h0);
        checks++; if (readyObs1 !== 3'b100 || oeObs1 !== 3'b010) begin errors++; $display("FAIL b2b_first_timing got %b/%b want 100/010", readyObs1, oeObs1); end
        checks++; if (rdObs1[2] !== 32'hCAFE0001) begin errors++; $display("FAIL b2b_first_data got %h want cafe0001", rdObs1[2]); end
        runAccess1(1'b1, 1'b0, 32'd1036, 32'h0);
        checks++; if (readyObs1 !== 3'b100 || oeObs1 !== 3'b010) begin errors++; $display("FAIL b2b_second_timing got %b/%b want 100/010", readyObs1, oeObs1); end
        checks++; if (rdObs1[1] !== 32'hCAFE0001 || rdObs1[2] !== 32'hCAFE0002) begin errors++; $display("FAIL b2b_second_data got %h/%h want cafe0001/cafe0002", rdObs1[1], rdObs1[2]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_reset_mid_access;
        test_store_load;
        test_address_map;
        test_out_of_range;
        test_simultaneous;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
